// File: rtl/guess_score_sequencer.sv
// Serial xA-yB scorer: one shared digit comparator, turn/win lock, circular guess history.
// Latency: done 18 cycles after an accepted start (2 cycles for a SCORE_DUP_REJECT_EN reject).
// Backpressure: start is dropped while busy or locked; clear aborts and wins over start.
module guess_score_sequencer #(
  parameter int HIST_DEPTH = 8,
  parameter int MAX_TURNS  = 6
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic        clear,
  input  logic [15:0] secret,
  input  logic [15:0] guess,
  output logic        busy,
  output logic        done,
  output logic [2:0]  count_a,
  output logic [2:0]  count_b,
  output logic        win,
  output logic        locked,
  output logic        reject,
  output logic [2:0]  turn_count,
  output logic [3:0]  hist_count,
  input  logic [2:0]  hist_rd_idx,
  output logic [21:0] hist_rd_data
);

  localparam int PW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, COMPARE, FINISH} state_t;

  state_t          state_q, state_d;
  logic [15:0]     snap_secret, snap_guess;
  logic [3:0]      pair_q;
  logic [2:0]      acc_a, acc_b;
  logic [PW-1:0]   wr_ptr, rd_addr;
  logic [21:0]     hist_mem [HIST_DEPTH];
  logic [3:0]      s_dig, g_dig;
  logic            accept, dup, rej_pend, digit_hit;

  assign busy   = (state_q != IDLE);
  assign locked = win || (turn_count == 3'(MAX_TURNS));
  assign accept = (state_q == IDLE) && start && !locked && !clear;

  // pair_q = {i, j}; counting down from 15 walks j fastest from (3,3) to (0,0)
  assign s_dig     = snap_secret[{pair_q[3:2], 2'b00} +: 4];
  assign g_dig     = snap_guess[{pair_q[1:0], 2'b00} +: 4];
  assign digit_hit = (s_dig == g_dig) && (s_dig != 4'hF);

`ifdef SCORE_DUP_REJECT_EN
  function automatic logic has_dup(input logic [15:0] g);
    has_dup = 1'b0;
    for (int x = 0; x < 4; x++)
      for (int y = x + 1; y < 4; y++)
        if (g[x*4 +: 4] == g[y*4 +: 4] && g[x*4 +: 4] != 4'hF) has_dup = 1'b1;
  endfunction

  assign dup = has_dup(guess);

  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      rej_pend <= 1'b0;
      reject   <= 1'b0;
    end else begin
      reject <= (state_q == FINISH) && rej_pend;
      if (accept) rej_pend <= dup;
    end
  end
`else
  assign dup      = 1'b0;
  assign rej_pend = 1'b0;
  assign reject   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = dup ? FINISH : COMPARE;
      COMPARE: if (pair_q == 4'd0) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      snap_secret <= '0;
      snap_guess  <= '0;
      pair_q      <= '0;
      acc_a       <= '0;
      acc_b       <= '0;
      done        <= 1'b0;
      count_a     <= '0;
      count_b     <= '0;
      win         <= 1'b0;
      turn_count  <= '0;
      hist_count  <= '0;
      wr_ptr      <= '0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      if (clear) begin
        count_a    <= '0;
        count_b    <= '0;
        win        <= 1'b0;
        turn_count <= '0;
        hist_count <= '0;
        wr_ptr     <= '0;
      end else begin
        case (state_q)
          IDLE: if (accept) begin
            snap_secret <= secret;
            snap_guess  <= guess;
            acc_a       <= '0;
            acc_b       <= '0;
            pair_q      <= 4'hF;
          end
          COMPARE: begin
            // b can exceed 7 when both words repeat digits; hold it at the 3-bit ceiling
            if (digit_hit) begin
              if (pair_q[3:2] == pair_q[1:0]) acc_a <= acc_a + 3'd1;
              else if (acc_b != 3'd7)         acc_b <= acc_b + 3'd1;
            end
            pair_q <= pair_q - 4'd1;
          end
          FINISH: begin
            done <= 1'b1;
            if (!rej_pend) begin
              count_a <= acc_a;
              count_b <= acc_b;
              if (acc_a == 3'd4) win <= 1'b1;
              if (turn_count != 3'(MAX_TURNS)) turn_count <= turn_count + 3'd1;
              if (hist_count != 4'(HIST_DEPTH)) hist_count <= hist_count + 4'd1;
              wr_ptr <= wr_ptr + PW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && !clear && state_q == FINISH && !rej_pend)
      hist_mem[wr_ptr] <= {snap_guess, acc_a, acc_b};
  end

  // Oldest surviving entry sits hist_count slots behind the write pointer
  assign rd_addr      = wr_ptr - PW'(hist_count) + PW'(hist_rd_idx);
  assign hist_rd_data = ({1'b0, hist_rd_idx} < hist_count) ? hist_mem[rd_addr] : 22'h0;

endmodule

// File: tb/tb_guess_score_sequencer.sv
// Randomized bench for guess_score_sequencer against a rules-level scoring/history model.
module tb_guess_score_sequencer;

  localparam int HD = 4;
  localparam int MT = 6;
`ifdef SCORE_DUP_REJECT_EN
  localparam bit DUP_EN = 1'b1;
`else
  localparam bit DUP_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET, start, clear;
  logic [15:0] secret, guess;
  logic        busy, done, win, locked, reject;
  logic [2:0]  count_a, count_b, turn_count, hist_rd_idx;
  logic [3:0]  hist_count;
  logic [21:0] hist_rd_data;

  guess_score_sequencer #(.HIST_DEPTH(HD), .MAX_TURNS(MT)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .clear(clear),
    .secret(secret), .guess(guess), .busy(busy), .done(done),
    .count_a(count_a), .count_b(count_b), .win(win), .locked(locked),
    .reject(reject), .turn_count(turn_count), .hist_count(hist_count),
    .hist_rd_idx(hist_rd_idx), .hist_rd_data(hist_rd_data)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  int          m_turn, m_a, m_b;
  bit          m_win, m_rej;
  logic [21:0] m_hist[$];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic bit m_dup(input logic [15:0] g);
    logic [3:0] d [4];
    for (int k = 0; k < 4; k++) d[k] = 4'((g >> (4 * k)) & 16'hF);
    m_dup = 1'b0;
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        if (x != y && d[x] == d[y] && d[x] != 4'hF) m_dup = 1'b1;
  endfunction

  function automatic bit m_locked();
    return m_win || (m_turn == MT);
  endfunction

  function automatic logic [21:0] m_hist_rd(input int idx);
    return (idx < m_hist.size()) ? m_hist[idx] : 22'h0;
  endfunction

  task automatic model_clear();
    m_turn = 0; m_a = 0; m_b = 0; m_win = 0; m_rej = 0;
    m_hist.delete();
  endtask

  // Scoring from the game rules: each secret digit against each guess digit
  task automatic model_apply(input logic [15:0] s, input logic [15:0] g);
    int a, b;
    logic [3:0] sd, gd;
    m_rej = DUP_EN && m_dup(g);
    if (m_rej) return;
    a = 0; b = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        sd = 4'((s >> (4 * i)) & 16'hF);
        gd = 4'((g >> (4 * j)) & 16'hF);
        if (sd == gd && sd != 4'hF) begin
          if (i == j) a++;
          else b++;
        end
      end
    if (b > 7) b = 7;
    m_a = a; m_b = b;
    if (a == 4) m_win = 1;
    if (m_turn < MT) m_turn++;
    m_hist.push_back({g, 3'(a), 3'(b)});
    if (m_hist.size() > HD) void'(m_hist.pop_front());
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
  endtask

  // Pulses start and returns the cycle index at which done appeared (cycle 0 = start sampled)
  task automatic do_guess(input logic [15:0] s, input logic [15:0] g,
                          output int lat, output bit busy_ok);
    secret = s; guess = g; start = 1'b1;
    tick();
    start = 1'b0;
    secret = 16'($urandom); guess = 16'($urandom);
    lat = 1; busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      lat++;
    end
    if (busy !== 1'b0) busy_ok = 1'b0;
  endtask

  function automatic logic [15:0] rand_nodup();
    int d [10];
    logic [15:0] g;
    for (int k = 0; k < 10; k++) d[k] = k;
    for (int k = 0; k < 4; k++) begin
      int r, t;
      r = $urandom_range(k, 9);
      t = d[k]; d[k] = d[r]; d[r] = t;
    end
    g = {4'(d[0]), 4'(d[1]), 4'(d[2]), 4'(d[3])};
    if (g == 16'h1234) g = 16'h4321;
    return g;
  endfunction

  task automatic test_reset();
    n_chk++;
    if ({busy, done, count_a, count_b, win, locked, reject, turn_count, hist_count} !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0",
               {busy, done, count_a, count_b, win, locked, reject, turn_count, hist_count});
    end
    n_chk++;
    if (hist_rd_data !== 22'h0) begin
      n_fail++; $display("FAIL reset_hist: got %h required 0", hist_rd_data);
    end
  endtask

  task automatic test_basic_score();
    int lat; bit bok;
    do_clear();
    do_guess(16'h1234, 16'h1243, lat, bok);
    model_apply(16'h1234, 16'h1243);
    n_chk++;
    if (lat !== 18 || !bok) begin
      n_fail++; $display("FAIL basic_latency: got %0d busy_ok %0d required 18 1", lat, bok);
    end
    n_chk++;
    if ({count_a, count_b, turn_count} !== {3'd2, 3'd2, 3'd1}) begin
      n_fail++; $display("FAIL basic_counts: a=%0d b=%0d turn=%0d required 2 2 1", count_a, count_b, turn_count);
    end
    hist_rd_idx = 3'd0; #1;
    n_chk++;
    if (hist_rd_data !== {16'h1243, 3'd2, 3'd2}) begin
      n_fail++; $display("FAIL basic_hist0: got %h required %h", hist_rd_data, {16'h1243, 3'd2, 3'd2});
    end
    hist_rd_idx = 3'd1; #1;
    n_chk++;
    if (hist_rd_data !== 22'h0) begin
      n_fail++; $display("FAIL basic_hist_oob: got %h required 0", hist_rd_data);
    end
  endtask

  task automatic test_blanks();
    int lat; bit bok;
    do_clear();
    do_guess(16'h1234, 16'h56FF, lat, bok);
    n_chk++;
    if ({count_a, count_b} !== 6'd0) begin
      n_fail++; $display("FAIL nomatch: a=%0d b=%0d required 0 0", count_a, count_b);
    end
    do_guess(16'hF234, 16'hF234, lat, bok);
    n_chk++;
    if ({count_a, count_b, win} !== {3'd3, 3'd0, 1'b0}) begin
      n_fail++; $display("FAIL blanks: a=%0d b=%0d win=%0d required 3 0 0", count_a, count_b, win);
    end
  endtask

  task automatic test_win_lock();
    int lat, dones; bit bok;
    do_clear();
    do_guess(16'h1234, 16'h1234, lat, bok);
    n_chk++;
    if ({count_a, win, locked} !== {3'd4, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL win: a=%0d win=%0d locked=%0d required 4 1 1", count_a, win, locked);
    end
    start = 1'b1; tick(); start = 1'b0;
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy !== 1'b0 || done !== 1'b0) dones++;
      tick();
    end
    n_chk++;
    if (dones !== 0) begin
      n_fail++; $display("FAIL win_ignores_start: busy/done seen %0d cycles required 0", dones);
    end
    do_clear();
    n_chk++;
    if ({locked, win, turn_count} !== 5'd0) begin
      n_fail++; $display("FAIL win_clear: locked=%0d win=%0d turn=%0d required 0", locked, win, turn_count);
    end
  endtask

  task automatic test_turn_limit();
    int lat; bit bok;
    logic [15:0] g [6];
    logic [21:0] e [6];
    do_clear();
    for (int k = 0; k < 6; k++) begin
      g[k] = rand_nodup();
      do_guess(16'h1234, g[k], lat, bok);
      model_apply(16'h1234, g[k]);
      e[k] = {g[k], 3'(m_a), 3'(m_b)};
      n_chk++;
      if ({count_a, count_b, turn_count} !== {3'(m_a), 3'(m_b), 3'(m_turn)}) begin
        n_fail++; $display("FAIL limit_turn%0d: a=%0d b=%0d turn=%0d required %0d %0d %0d",
                           k, count_a, count_b, turn_count, m_a, m_b, m_turn);
      end
    end
    n_chk++;
    if ({locked, hist_count} !== {1'b1, 4'd4}) begin
      n_fail++; $display("FAIL limit_lock: locked=%0d hist_count=%0d required 1 4", locked, hist_count);
    end
    hist_rd_idx = 3'd0; #1;
    n_chk++;
    if (hist_rd_data !== e[2]) begin
      n_fail++; $display("FAIL limit_oldest: got %h required %h", hist_rd_data, e[2]);
    end
    hist_rd_idx = 3'd3; #1;
    n_chk++;
    if (hist_rd_data !== e[5]) begin
      n_fail++; $display("FAIL limit_newest: got %h required %h", hist_rd_data, e[5]);
    end
    hist_rd_idx = 3'd5; #1;
    n_chk++;
    if (hist_rd_data !== 22'h0) begin
      n_fail++; $display("FAIL limit_oob: got %h required 0", hist_rd_data);
    end
    start = 1'b1; tick(); start = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || turn_count !== 3'(MT)) begin
      n_fail++; $display("FAIL limit_7th: busy=%0d turn=%0d required 0 %0d", busy, turn_count, MT);
    end
  endtask

  task automatic test_abort();
    int lat, dones; bit bok;
    do_clear();
    do_guess(16'h1234, 16'h1243, lat, bok);
    secret = 16'h1234; guess = 16'h1324; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 8; k++) tick();
    clear = 1'b1; tick(); clear = 1'b0;
    model_clear();
    n_chk++;
    if ({busy, done, count_a, count_b, turn_count, hist_count, win, locked} !== 18'h0) begin
      n_fail++; $display("FAIL abort_zero: busy=%0d done=%0d a=%0d b=%0d turn=%0d hist=%0d required all 0",
                         busy, done, count_a, count_b, turn_count, hist_count);
    end
    dones = 0;
    for (int k = 0; k < 25; k++) begin
      if (done !== 1'b0 || hist_count !== 4'd0) dones++;
      tick();
    end
    n_chk++;
    if (dones !== 0) begin
      n_fail++; $display("FAIL abort_no_done: done/history seen %0d cycles required 0", dones);
    end
    secret = 16'h1234; guess = 16'h4321;
    start = 1'b1; clear = 1'b1; tick(); start = 1'b0; clear = 1'b0;
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy !== 1'b0 || done !== 1'b0) dones++;
      tick();
    end
    n_chk++;
    if (dones !== 0) begin
      n_fail++; $display("FAIL clear_beats_start: busy/done seen %0d cycles required 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2; bit bok1, bok2;
    logic [15:0] s, g1, g2;
    do_clear();
    s = rand_nodup(); g1 = rand_nodup(); g2 = rand_nodup();
    if (g1 == s) g1 = 16'h5F6F;
    if (g2 == s) g2 = 16'hF7F8;
    do_guess(s, g1, lat1, bok1);
    model_apply(s, g1);
    do_guess(s, g2, lat2, bok2);
    model_apply(s, g2);
    n_chk++;
    if (lat1 !== 18 || lat2 !== 18 || !bok2) begin
      n_fail++; $display("FAIL b2b_latency: got %0d %0d busy_ok %0d required 18 18 1", lat1, lat2, bok2);
    end
    hist_rd_idx = 3'd1; #1;
    n_chk++;
    if ({count_a, count_b, turn_count, hist_rd_data} !== {3'(m_a), 3'(m_b), 3'(m_turn), m_hist_rd(1)}) begin
      n_fail++; $display("FAIL b2b_result: a=%0d b=%0d turn=%0d hist=%h required %0d %0d %0d %h",
                         count_a, count_b, turn_count, hist_rd_data, m_a, m_b, m_turn, m_hist_rd(1));
    end
  endtask

  task automatic test_dup();
    int lat; bit bok;
    do_clear();
    do_guess(16'h1234, 16'h1123, lat, bok);
    model_apply(16'h1234, 16'h1123);
    n_chk++;
    if (lat !== (DUP_EN ? 2 : 18) || reject !== DUP_EN) begin
      n_fail++; $display("FAIL dup_timing: lat=%0d reject=%0d required %0d %0d",
                         lat, reject, DUP_EN ? 2 : 18, DUP_EN);
    end
    n_chk++;
    if ({count_a, count_b, turn_count} !== (DUP_EN ? 9'd0 : {3'd1, 3'd3, 3'd1})) begin
      n_fail++; $display("FAIL dup_result: a=%0d b=%0d turn=%0d", count_a, count_b, turn_count);
    end
  endtask

  task automatic test_random();
    int lat; bit bok;
    logic [15:0] s, g;
    logic [3:0] d;
    int idx;
    do_clear();
    for (int n = 0; n < 30; n++) begin
      if (m_locked()) do_clear();
      for (int k = 0; k < 4; k++) begin
        d = 4'($urandom_range(1, 5)); s[k*4 +: 4] = (d == 4'd5) ? 4'hF : d;
        d = 4'($urandom_range(1, 5)); g[k*4 +: 4] = (d == 4'd5) ? 4'hF : d;
      end
      if ($urandom_range(0, 5) == 0) g = s;
      do_guess(s, g, lat, bok);
      model_apply(s, g);
      n_chk++;
      if (lat !== (m_rej ? 2 : 18) || !bok || reject !== m_rej) begin
        n_fail++; $display("FAIL rand%0d_timing: lat=%0d busy_ok=%0d reject=%0d required %0d 1 %0d",
                           n, lat, bok, reject, m_rej ? 2 : 18, m_rej);
      end
      n_chk++;
      if ({count_a, count_b, turn_count, hist_count, win, locked} !==
          {3'(m_a), 3'(m_b), 3'(m_turn), 4'(m_hist.size()), m_win, m_locked()}) begin
        n_fail++; $display("FAIL rand%0d_state s=%h g=%h: a=%0d b=%0d turn=%0d hc=%0d win=%0d lk=%0d required %0d %0d %0d %0d %0d %0d",
                           n, s, g, count_a, count_b, turn_count, hist_count, win, locked,
                           m_a, m_b, m_turn, m_hist.size(), m_win, m_locked());
      end
      idx = $urandom_range(0, 7);
      hist_rd_idx = 3'(idx); #1;
      n_chk++;
      if (hist_rd_data !== m_hist_rd(idx)) begin
        n_fail++; $display("FAIL rand%0d_hist idx=%0d: got %h required %h", n, idx, hist_rd_data, m_hist_rd(idx));
      end
    end
  endtask

  initial begin
    RESET = 1'b1; start = 1'b0; clear = 1'b0;
    secret = '0; guess = '0; hist_rd_idx = '0;
    model_clear();
    tick(); tick();
    RESET = 1'b0;
    #1;
    test_reset();
    test_basic_score();
    test_blanks();
    test_win_lock();
    test_turn_limit();
    test_abort();
    test_back_to_back();
    test_dup();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
